asic_rrarb4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource between up to four requesters (e.g. the request lines otherwise merged by a 4-input NOR/OR reduce tree). Grants are registered one-hot, held for a multi-beat burst until the winner signals its final beat or drops its request, then rotated fairly. Sits in front of any shared asiclib datapath or bus port that accepts one requester at a time.

---
 rtl/asic_rrarb4_if.sv | 14 +
 rtl/asic_rrarb4.sv | 130 +++++++++++++
 tb/tb_asic_rrarb4.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/asic_rrarb4_if.sv
// Requester/resource handshake bundle for the asic_rrarb4 round-robin arbiter.
// The slave modport is the arbiter's view; master is the requester/resource side.
interface asic_rrarb4_if;
    logic [3:0] req;
    logic [3:0] last;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       busy;

    modport master (output req, last, ready, input grant, sel, valid, busy);
    modport slave  (input req, last, ready, output grant, sel, valid, busy);
endinterface

// File: rtl/asic_rrarb4.sv
// Four-requester round-robin arbiter with registered one-hot grant held per burst.
// Optional hold limit (MAXBEATS beats per grant) when ASIC_RRARB4_HOLDLIMIT_EN is defined.
//
// state | meaning
// IDLE  | no owner, grant = 0
// OWNED | grant one-hot, owner index in sel_q
module asic_rrarb4 #(
    parameter     PROP     = "DEFAULT",
    parameter int MAXBEATS = 8
) (
    input logic          clk,
    input logic          reset,
    asic_rrarb4_if.slave arb
);

    typedef enum logic {IDLE, OWNED} state_t;

    if (MAXBEATS < 1 || MAXBEATS > 255) begin : g_bad_maxbeats
        $error("asic_rrarb4: MAXBEATS must be in 1..255");
    end
    if ($bits(PROP) == 0) begin : g_bad_prop
        $error("asic_rrarb4: PROP must be non-empty");
    end

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic       busy_q;
    logic       accept;
    logic       release_now;
    logic       hold_hit;
    logic       arbitrate;
    logic       found;
    logic [3:0] mask;
    logic [3:0] others;
    logic [1:0] idx;

`ifdef ASIC_RRARB4_HOLDLIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    assign hold_hit = accept && (cnt_q == 8'(MAXBEATS - 1));
`else
    assign hold_hit = 1'b0;
`endif

    assign arb.valid   = |(arb.req & grant_q);
    assign arb.grant   = grant_q;
    assign arb.sel     = sel_q;
    assign arb.busy    = busy_q;
    assign accept      = arb.valid & arb.ready;
    assign release_now = (accept & arb.last[sel_q]) | ~arb.req[sel_q] | hold_hit;
    assign others      = arb.req & ~grant_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        arbitrate = 1'b0;
        found     = 1'b0;
        mask      = 4'b0000;
        idx       = 2'd0;
`ifdef ASIC_RRARB4_HOLDLIMIT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|arb.req) begin
                    arbitrate = 1'b1;
                    mask      = arb.req;
                end
            end
            OWNED: begin
`ifdef ASIC_RRARB4_HOLDLIMIT_EN
                if (accept) cnt_d = cnt_q + 8'd1;
`endif
                if (release_now) begin
                    arbitrate = 1'b1;
                    // the releasing owner only wins again when nobody else is waiting
                    mask      = (|others) ? others : arb.req;
                end
            end
            default: state_d = IDLE;
        endcase

        if (arbitrate) begin
            state_d = IDLE;
            grant_d = 4'b0000;
            sel_d   = 2'd0;
`ifdef ASIC_RRARB4_HOLDLIMIT_EN
            cnt_d   = 8'd0;
`endif
            for (int i = 1; i <= 4; i++) begin
                if (!found && mask[ptr_q + 2'(i)]) begin
                    found = 1'b1;
                    idx   = ptr_q + 2'(i);
                end
            end
            if (found) begin
                state_d = OWNED;
                grant_d = 4'b0001 << idx;
                sel_d   = idx;
                ptr_d   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            busy_q  <= 1'b0;
`ifdef ASIC_RRARB4_HOLDLIMIT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= |grant_d;
`ifdef ASIC_RRARB4_HOLDLIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_asic_rrarb4.sv
// Directed bench for asic_rrarb4: rotation, bursts, ready stall, req drop, reset, hold limit.
module tb_asic_rrarb4;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    asic_rrarb4_if ifc ();

    asic_rrarb4 #(.PROP("DEFAULT"), .MAXBEATS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_s;
        total = 0;
        bad   = 0;
        ifc.req   = 4'b0000;
        ifc.last  = 4'b0000;
        ifc.ready = 1'b0;
        reset     = 1'b0;
        #2 reset = 1'b1;
        #2;
        chk("rst_grant", 32'(ifc.grant), 32'h0);
        chk("rst_sel",   32'(ifc.sel),   32'h0);
        chk("rst_busy",  32'(ifc.busy),  32'h0);
        chk("rst_valid", 32'(ifc.valid), 32'h0);

        // all requesting single-beat bursts: strict rotation from requester 0
        ifc.req   = 4'b1111;
        ifc.last  = 4'b1111;
        ifc.ready = 1'b1;
        tick();
        chk("rst_hold_grant", 32'(ifc.grant), 32'h0);
        chk("rst_hold_valid", 32'(ifc.valid), 32'h0);
        #2 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_s = 2'(k % 4);
            exp_g = 4'b0001 << exp_s;
            tick();
            chk("rot_grant", 32'(ifc.grant), 32'(exp_g));
            chk("rot_sel",   32'(ifc.sel),   32'(exp_s));
            chk("rot_busy",  32'(ifc.busy),  32'h1);
        end
        ifc.req  = 4'b0000;
        ifc.last = 4'b0000;
        tick();
        chk("rot_idle_grant", 32'(ifc.grant), 32'h0);
        chk("rot_idle_busy",  32'(ifc.busy),  32'h0);

        // 4-beat burst from requester 2; requester 0 waits and takes over with no bubble
        ifc.req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("burst_grant", 32'(ifc.grant), 32'h4);
            chk("burst_sel",   32'(ifc.sel),   32'h2);
        end
        ifc.last = 4'b0100;
        ifc.req  = 4'b0101;
        tick();
        chk("burst_handoff", 32'(ifc.grant), 32'h1);
        ifc.req  = 4'b0000;
        ifc.last = 4'b0000;
        tick();
        chk("burst_idle", 32'(ifc.grant), 32'h0);

        // ready stall on requester 1 with requester 0 pending
        ifc.req   = 4'b0011;
        ifc.last  = 4'b0010;
        ifc.ready = 1'b0;
        tick();
        chk("stall_grant0", 32'(ifc.grant), 32'h2);
        chk("stall_sel0",   32'(ifc.sel),   32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_hold", 32'(ifc.grant), 32'h2);
        end
        ifc.ready = 1'b1;
        tick();
        chk("stall_release", 32'(ifc.grant), 32'h1);
        ifc.req = 4'b0000;
        tick();
        chk("stall_idle", 32'(ifc.grant), 32'h0);

        // requester 3 drops req while granted; requester 0 takes over next edge
        ifc.req  = 4'b1000;
        ifc.last = 4'b0000;
        tick();
        chk("drop_grant3", 32'(ifc.grant), 32'h8);
        chk("drop_sel3",   32'(ifc.sel),   32'h3);
        ifc.req = 4'b0001;
        #1;
        chk("drop_valid", 32'(ifc.valid), 32'h0);
        tick();
        chk("drop_grant0", 32'(ifc.grant), 32'h1);
        chk("drop_busy",   32'(ifc.busy),  32'h1);
        ifc.req = 4'b0000;
        tick();
        chk("drop_idle", 32'(ifc.grant), 32'h0);

        // asynchronous reset mid-burst, then arbitration restarts from ptr=3
        ifc.req = 4'b0100;
        tick();
        chk("mid_grant", 32'(ifc.grant), 32'h4);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(ifc.grant), 32'h0);
        chk("mid_rst_valid", 32'(ifc.valid), 32'h0);
        chk("mid_rst_busy",  32'(ifc.busy),  32'h0);
        ifc.req = 4'b1100;
        #3 reset = 1'b0;
        tick();
        chk("post_rst_grant", 32'(ifc.grant), 32'h4);
        chk("post_rst_sel",   32'(ifc.sel),   32'h2);
        ifc.req = 4'b0000;
        tick();

        // long bursts without last: hold limit alternates, otherwise requester 0 keeps it
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        ifc.req   = 4'b0011;
        ifc.last  = 4'b0000;
        ifc.ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
`ifdef ASIC_RRARB4_HOLDLIMIT_EN
            exp_g = (((k / 8) % 2) == 1) ? 4'b0010 : 4'b0001;
`else
            exp_g = 4'b0001;
`endif
            tick();
            chk("hold_grant", 32'(ifc.grant), 32'(exp_g));
        end
        ifc.req = 4'b0000;
        tick();
        chk("hold_idle", 32'(ifc.grant), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
